// File: rtl/eq_serial_sched_if.sv
// Request/response bundle for eq_serial_sched. Two requesters present
// operand pairs; one consumer takes the equality result.
interface eq_serial_sched_if #(
    parameter int WIDTH = 8
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_ready;

    logic             req1_valid;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_ready;

    logic             rsp_valid;
    logic             rsp_id;
    logic             rsp_eq;
    logic             rsp_ready;

    // Producer/consumer side: drives requests, accepts results.
    modport master (
        output req0_valid, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_a, req1_b,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_eq,
        output rsp_ready
    );

    // Scheduler side.
    modport slave (
        input  req0_valid, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_a, req1_b,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_eq,
        input  rsp_ready
    );
endinterface

// File: rtl/eq_serial_sched.sv
// Serial equality scheduler. Two requesters share one 2-bit sum-of-products
// equality slice; operands are compared LSB slice first, two bits per cycle,
// stopping at the first mismatching slice. WIDTH must be even and >= 2.
module eq_serial_sched #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    eq_serial_sched_if.slave  bus
);
    localparam int NS = WIDTH / 2;
    localparam int IW = (NS > 1) ? $clog2(NS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMP,
        S_RESP
    } state_t;

    // 2-bit equality written as the four matching minterms.
    function automatic logic eq2_sop(input logic [1:0] x, input logic [1:0] y);
        return (~x[1] & ~x[0] & ~y[1] & ~y[0]) |
               (~x[1] &  x[0] & ~y[1] &  y[0]) |
               ( x[1] & ~x[0] &  y[1] & ~y[0]) |
               ( x[1] &  x[0] &  y[1] &  y[0]);
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             id_q, id_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             eq_acc_q, eq_acc_d;
    logic             last_id_q, last_id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic             rsp_eq_q, rsp_eq_d;

    logic             grant0;
    logic             grant1;
    logic [1:0]       slice_a;
    logic [1:0]       slice_b;
    logic             slice_eq;

    // Current slice of the latched operands feeding the shared comparator.
    assign slice_a  = a_q[{idx_q, 1'b0} +: 2];
    assign slice_b  = b_q[{idx_q, 1'b0} +: 2];
    assign slice_eq = eq2_sop(slice_a, slice_b);

    // Next-state, arbitration and datapath control.
    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one unassigned, which would infer a latch.
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        idx_d       = idx_q;
        eq_acc_d    = eq_acc_q;
        last_id_d   = last_id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_eq_d    = rsp_eq_q;
        grant0      = 1'b0;
        grant1      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // On a tie the requester that was not served last wins.
                if (bus.req0_valid && (!bus.req1_valid || last_id_q)) begin
                    grant0 = 1'b1;
                end else if (bus.req1_valid) begin
                    grant1 = 1'b1;
                end

                if (grant0 || grant1) begin
                    a_d      = grant1 ? bus.req1_a : bus.req0_a;
                    b_d      = grant1 ? bus.req1_b : bus.req0_b;
                    id_d     = grant1;
                    idx_d    = '0;
                    eq_acc_d = 1'b1;
                    state_d  = S_CMP;
                end
            end

            S_CMP: begin
                if (!slice_eq) begin
                    // Early termination on the first differing slice.
                    eq_acc_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_eq_d    = 1'b0;
                    state_d     = S_RESP;
                end else if (idx_q == IW'(NS - 1)) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_eq_d    = eq_acc_q;
                    state_d     = S_RESP;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            S_RESP: begin
                // Result held stable until the consumer takes it.
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    last_id_d   = rsp_id_q;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any in-flight compare.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= 1'b0;
            idx_q       <= '0;
            eq_acc_q    <= 1'b1;
            last_id_q   <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_eq_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            idx_q       <= idx_d;
            eq_acc_q    <= eq_acc_d;
            last_id_q   <= last_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_eq_q    <= rsp_eq_d;
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_eq     = rsp_eq_q;

endmodule

// File: tb/tb_eq_serial_sched.sv
// Directed bench for eq_serial_sched (WIDTH=8): reset, table of single
// transactions, mid-compare reset, round-robin ties and response backpressure.
module tb_eq_serial_sched;
    logic clk;
    logic rst_n;
    int   tests;
    int   errors;

    eq_serial_sched_if #(.WIDTH(8)) bus ();

    eq_serial_sched #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         id;
        logic [7:0] a;
        logic [7:0] b;
        bit         exp_eq;
        int         exp_k;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input bit id, input bit v, input logic [7:0] a, input logic [7:0] b);
        if (id) begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b;
        end
    endtask

    task automatic idle_inputs();
        set_req(1'b0, 1'b0, 8'h00, 8'h00);
        set_req(1'b1, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        bus.rsp_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One transaction with rsp_ready=1: checks accept, latency, result and
    // that the result lasts exactly one cycle; operands are disturbed after accept.
    task automatic run_txn(input vec_t v, input string tag);
        bit acc;
        bit seen;
        int lat;
        acc  = 1'b0;
        seen = 1'b0;
        lat  = -1;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 10 && !acc; i++) begin
            @(negedge clk);
            set_req(v.id, 1'b1, v.a, v.b);
            #1;
            if (v.id ? bus.req1_ready : bus.req0_ready) acc = 1'b1;
        end
        check({tag, "_accept"}, acc, 1);
        check({tag, "_other_ready"}, v.id ? bus.req0_ready : bus.req1_ready, 0);
        for (int i = 1; i <= 12 && !seen; i++) begin
            @(negedge clk);
            if (i == 1) begin
                // Values that would flip the result if resampled.
                set_req(v.id, 1'b0, v.exp_eq ? ~v.b : v.b, v.b);
            end
            #1;
            if (i == 1) check({tag, "_ready_in_cmp"}, {bus.req0_ready, bus.req1_ready}, 0);
            if (bus.rsp_valid) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        check({tag, "_latency"}, lat, v.exp_k + 1);
        check({tag, "_rsp_id"}, bus.rsp_id, v.id);
        check({tag, "_rsp_eq"}, bus.rsp_eq, v.exp_eq);
        @(negedge clk);
        #1;
        check({tag, "_rsp_one_cycle"}, bus.rsp_valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int grants[$];
        int rsps[$];
        int rises;
        bit seen;

        tests  = 0;
        errors = 0;

        vecs[0] = '{id: 1'b0, a: 8'hA5, b: 8'hA5, exp_eq: 1'b1, exp_k: 4};
        vecs[1] = '{id: 1'b1, a: 8'h01, b: 8'h00, exp_eq: 1'b0, exp_k: 1};
        vecs[2] = '{id: 1'b0, a: 8'h40, b: 8'h00, exp_eq: 1'b0, exp_k: 4};
        vecs[3] = '{id: 1'b1, a: 8'hFF, b: 8'hFF, exp_eq: 1'b1, exp_k: 4};
        vecs[4] = '{id: 1'b0, a: 8'h0C, b: 8'h00, exp_eq: 1'b0, exp_k: 2};
        vecs[5] = '{id: 1'b1, a: 8'h00, b: 8'h30, exp_eq: 1'b0, exp_k: 3};
        vecs[6] = '{id: 1'b0, a: 8'h00, b: 8'h00, exp_eq: 1'b1, exp_k: 4};
        vecs[7] = '{id: 1'b1, a: 8'h80, b: 8'h00, exp_eq: 1'b0, exp_k: 4};
        vecs[8] = '{id: 1'b0, a: 8'h12, b: 8'h12, exp_eq: 1'b1, exp_k: 4};
        vecs[9] = '{id: 1'b1, a: 8'h3C, b: 8'h3D, exp_eq: 1'b0, exp_k: 1};

        // Reset with no requests: all outputs low, and they stay low.
        rst_n = 1'b0;
        idle_inputs();
        bus.rsp_ready = 1'b0;
        #1;
        check("reset_outputs", {bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_eq}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("idle_outputs", {bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_eq}, 0);
        end

        // Reset asserted mid-compare: that request never responds.
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        set_req(1'b0, 1'b1, 8'hA5, 8'hA5);
        #1;
        check("midrst_accept", bus.req0_ready, 1);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_rsp_in_reset", bus.rsp_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        rises = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            if (bus.rsp_valid) rises++;
        end
        check("midrst_no_rsp", rises, 0);

        // Table of single transactions.
        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Both requesters valid continuously: grants alternate from req0.
        do_reset();
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 60 && rsps.size() < 4; i++) begin
            @(negedge clk);
            set_req(1'b0, 1'b1, 8'h11, 8'h11);
            set_req(1'b1, 1'b1, 8'h01, 8'h00);
            #1;
            if (bus.req0_ready && grants.size() < 4) grants.push_back(0);
            if (bus.req1_ready && grants.size() < 4) grants.push_back(1);
            if (bus.rsp_valid) rsps.push_back(int'(bus.rsp_id));
        end
        check("rr_grant_count", grants.size(), 4);
        check("rr_rsp_count", rsps.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rr_grant%0d", i), (i < grants.size()) ? grants[i] : -1, i % 2);
            check($sformatf("rr_rsp_id%0d", i), (i < rsps.size()) ? rsps[i] : -1, i % 2);
        end
        @(negedge clk);
        idle_inputs();
        repeat (8) @(negedge clk);

        // Backpressure: result held 6 cycles, no grants meanwhile.
        bus.rsp_ready = 1'b0;
        set_req(1'b1, 1'b1, 8'h0C, 8'h00);
        #1;
        check("bp_accept", bus.req1_ready, 1);
        @(negedge clk);
        set_req(1'b1, 1'b0, 8'h00, 8'h00);
        set_req(1'b0, 1'b1, 8'hFF, 8'hFF);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            #1;
            if (bus.rsp_valid) seen = 1'b1;
            else @(negedge clk);
        end
        check("bp_rsp_seen", seen, 1);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            check("bp_hold", {bus.rsp_valid, bus.rsp_id, bus.rsp_eq}, 3'b110);
            check("bp_no_grant", {bus.req0_ready, bus.req1_ready}, 0);
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        #1;
        check("bp_release_cycle", {bus.rsp_valid, bus.req0_ready}, 2'b10);
        @(negedge clk);
        #1;
        check("bp_next_grant", {bus.rsp_valid, bus.req0_ready}, 2'b01);
        @(negedge clk);
        idle_inputs();
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            #1;
            if (bus.rsp_valid) seen = 1'b1;
            else @(negedge clk);
        end
        check("bp_second_rsp", {seen, bus.rsp_id, bus.rsp_eq}, 3'b101);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule

// File: doc/eq_serial_sched.md
# eq_serial_sched

Serial equality scheduler that shares one 2-bit sum-of-products equality slice (eq2_sop) between two requesters. Each accepted request compares two WIDTH-bit operands two bits per cycle, LSB slice first, and stops early on the first mismatching slice. The result goes back through a valid/ready response channel. It sits between operand producers and any logic that needs wide equality results without building a WIDTH-bit comparator.

## Interface
- WIDTH, 8, operand width; must be even and ≥2; slice count NS = WIDTH/2
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has operands
- req0_a, req0_b  in  WIDTH  requester 0 operands
- req0_ready  out  1  requester 0 accepted this cycle
- req1_valid  in  1  requester 1 has operands
- req1_a, req1_b  in  WIDTH  requester 1 operands
- req1_ready  out  1  requester 1 accepted this cycle
- rsp_valid  out  1  result available
- rsp_id  out  1  requester that owns the result (0/1)
- rsp_eq  out  1  1 = operands equal
- rsp_ready  in  1  consumer takes result

## Operation
- One clock; reset is asynchronous and active-low.
- States: IDLE, CMP, RESP.
- IDLE:
  - If any reqN_valid is high, grant one requester and drive its reqN_ready high combinationally in the same cycle.
  - At that edge: latch a, b and id; set slice index idx=0 and eq_acc=1; go to CMP.
  - With no valid requests, stay in IDLE.
- Arbitration:
  - Only one requester valid: grant it.
  - Both valid: grant the one not in pointer last_id.
  - last_id updates to rsp_id on the response handshake.
  - After reset last_id=1, so req0 wins the first tie.
- CMP, one slice per cycle, feeding bits [2·idx+1 : 2·idx] of the latched a/b into the eq2_sop slice:
  - Slice unequal: eq_acc←0, go to RESP (early termination).
  - Slice equal and idx==NS-1: go to RESP with eq_acc=1.
  - Otherwise idx←idx+1.
- RESP:
  - rsp_valid=1; rsp_id and rsp_eq=eq_acc stay stable until rsp_ready.
  - On rsp_valid&rsp_ready: go to IDLE and update last_id.
- Both reqN_ready are 0 outside IDLE. Requests are never queued; a requester holds valid and operands until its ready is seen.
- A requester may drop valid before it is granted; nothing is recorded.
- Operands are sampled only on the handshake edge. Later input changes do not affect an in-flight compare.
- rsp_id and rsp_eq hold their last values while rsp_valid=0.

## Timing
- Reset values: req0_ready=0, req1_ready=0, rsp_valid=0, rsp_id=0, rsp_eq=0, state=IDLE, idx=0, last_id=1.
- Reset asserted mid-operation aborts the compare; no response is produced. After release the block is in IDLE next cycle.
- Accept at edge T. CMP runs k cycles, where k = index of the first mismatching slice + 1, or NS if all slices are equal.
- rsp_valid first high in cycle T+k+1:
  - Equal, WIDTH=8: 4 compare cycles.
  - Mismatch in slice 0: 1 compare cycle.
- rsp_ready may already be high when rsp_valid rises; the handshake then completes in that first RESP cycle.
- After the response handshake there is one IDLE cycle, in which the next accept can occur. Minimum request-to-request spacing is k+2 cycles.
- Worst-case latency for a waiting requester is one full foreign transaction plus response backpressure. Round-robin guarantees no starvation.

## Test plan
- Reset, WIDTH=8, no requests:
  - All outputs 0 and stay 0.
  - Assert rst_n low mid-CMP: rsp_valid never rises for that request.
- req0 a=0xA5, b=0xA5, rsp_ready=1:
  - req0_ready pulses at T.
  - 4 CMP cycles.
  - rsp_valid=1, rsp_id=0, rsp_eq=1 at T+5 for exactly one cycle.
- req1 a=0x01, b=0x00:
  - Mismatch in slice 0; rsp_valid at T+2, rsp_id=1, rsp_eq=0.
- a=0x40, b=0x00:
  - Mismatch in slice 3; rsp at T+5, rsp_eq=0.
  - Changing a/b after accept does not change the result.
- Both requesters valid continuously, rsp_ready=1:
  - Grants alternate 0,1,0,1 starting with req0.
  - rsp_id sequence matches the grant sequence.
- rsp_ready held 0 for 6 cycles:
  - rsp_valid, rsp_id and rsp_eq stay stable.
  - Both reqN_ready stay 0.
  - Next grant comes in the IDLE cycle after rsp_ready rises.
